// File: rtl/serial_pad_reader.sv
// Polls NUM_CONTROLLERS NES/SNES-style serial pads in parallel: latch strobe, shifted serial clock, inverted capture.
// Optional macro CONTROLLER_PRESS_DETECT_EN adds one-cycle newly-pressed flags alongside each published sample.
`timescale 1ns/1ps
module serial_pad_reader #(
    parameter int NUM_CONTROLLERS     = 2,
    parameter int BITS_PER_CONTROLLER = 8,
    parameter int CLK_DIV             = 4,
    parameter int LATCH_PULSE_WIDTH   = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start_fetch_i,
    output logic                                           busy_o,
    output logic                                           done_o,
    output logic                                           clk_o,
    output logic                                           latch_o,
    input  logic [NUM_CONTROLLERS-1:0]                     serial_LIST_ni,
    output logic [BITS_PER_CONTROLLER*NUM_CONTROLLERS-1:0] data_LIST_o,
    output logic [BITS_PER_CONTROLLER*NUM_CONTROLLERS-1:0] pressed_LIST_o
);

    localparam int B       = BITS_PER_CONTROLLER;
    localparam int W       = BITS_PER_CONTROLLER * NUM_CONTROLLERS;
    localparam int PER_MAX = (LATCH_PULSE_WIDTH > B) ? LATCH_PULSE_WIDTH : B;
    localparam int PW      = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PW-1:0] LAT_LAST = PW'(LATCH_PULSE_WIDTH - 1);
    localparam logic [PW-1:0] SH_LAST  = PW'(B - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            phase_q, phase_d;
    logic [PW-1:0]   per_q, per_d;
    logic [PW-1:0]   per_last;
    logic            clk_q, clk_d;
    logic            latch_q, latch_d;
    logic            done_q, done_d;
    logic [W-1:0]    data_q, data_d;
    logic [W-1:0]    shift_all;
    logic            sample_en;

    // Both LATCH and SHIFT are counted in whole clk_o periods: div -> half-period, phase -> half, per -> period.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        phase_d  = phase_q;
        per_d    = per_q;
        per_last = (state_q == ST_LATCH) ? LAT_LAST : SH_LAST;
        case (state_q)
            ST_IDLE: begin
                if (start_fetch_i) begin
                    state_d = ST_LATCH;
                    div_d   = '0;
                    phase_d = 1'b0;
                    per_d   = '0;
                end
            end
            ST_LATCH, ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (phase_q) begin
                        phase_d = 1'b0;
                        if (per_q == per_last) begin
                            per_d   = '0;
                            state_d = (state_q == ST_LATCH) ? ST_SHIFT : ST_DONE;
                        end else begin
                            per_d = per_q + 1'b1;
                        end
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        clk_d   = (state_d == ST_SHIFT) && phase_d;
        latch_d = (state_d == ST_LATCH);
        done_d  = (state_d == ST_DONE);
        data_d  = done_d ? shift_all : data_q;
    end

    // Capture on the final cycle of each low half, just before the pad sees the rising edge.
    assign sample_en = (state_q == ST_SHIFT) && !phase_q && (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            phase_q <= 1'b0;
            per_q   <= '0;
            clk_q   <= 1'b0;
            latch_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            per_q   <= per_d;
            clk_q   <= clk_d;
            latch_q <= latch_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_pad
            logic [B-1:0] pad_q, pad_d;
            logic [B-1:0] pad_shifted;

            if (B == 1) begin : g_one
                assign pad_shifted = ~serial_LIST_ni[gi];
            end else begin : g_many
                assign pad_shifted = {pad_q[B-2:0], ~serial_LIST_ni[gi]};
            end

            always_comb begin
                pad_d = sample_en ? pad_shifted : pad_q;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pad_q <= '0;
                end else begin
                    pad_q <= pad_d;
                end
            end

            assign shift_all[gi*B +: B] = pad_q;
        end
    endgenerate

`ifdef CONTROLLER_PRESS_DETECT_EN
    logic [W-1:0] pressed_q, pressed_d;

    always_comb begin
        pressed_d = done_d ? (shift_all & ~data_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_q <= '0;
        end else begin
            pressed_q <= pressed_d;
        end
    end

    assign pressed_LIST_o = pressed_q;
`else
    assign pressed_LIST_o = '0;
`endif

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign clk_o       = clk_q;
    assign latch_o     = latch_q;
    assign data_LIST_o = data_q;

endmodule

// File: tb/tb_serial_pad_reader.sv
// Scoreboard bench: two reader instances (default and 4x16-bit fast config) driven by behavioural pad models.
`timescale 1ns/1ps
module tb_serial_pad_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instance A: default parameters ----------------
    logic        start_a = 1'b0;
    logic        busy_a, done_a, clk_o_a, latch_a;
    logic [1:0]  serial_a;
    logic [15:0] data_a, pressed_a;

    serial_pad_reader dut_a (
        .clk(clk), .rst(rst), .start_fetch_i(start_a),
        .busy_o(busy_a), .done_o(done_a), .clk_o(clk_o_a), .latch_o(latch_a),
        .serial_LIST_ni(serial_a), .data_LIST_o(data_a), .pressed_LIST_o(pressed_a)
    );

    logic [7:0] pad_a [2];
    int idx_a = 0;
    always @(posedge latch_a or posedge clk_o_a) begin
        if (latch_a) idx_a = 0;
        else         idx_a = idx_a + 1;
    end
    always_comb begin
        serial_a = '1;
        for (int p = 0; p < 2; p++)
            if (idx_a < 8) serial_a[p] = ~pad_a[p][7 - idx_a];
    end

    // ---------------- instance B: 4 pads x 16 bits, fast ----------------
    logic        start_b = 1'b0;
    logic        busy_b, done_b, clk_o_b, latch_b;
    logic [3:0]  serial_b;
    logic [63:0] data_b, pressed_b;

    serial_pad_reader #(
        .NUM_CONTROLLERS(4), .BITS_PER_CONTROLLER(16), .CLK_DIV(1), .LATCH_PULSE_WIDTH(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start_fetch_i(start_b),
        .busy_o(busy_b), .done_o(done_b), .clk_o(clk_o_b), .latch_o(latch_b),
        .serial_LIST_ni(serial_b), .data_LIST_o(data_b), .pressed_LIST_o(pressed_b)
    );

    logic [15:0] pad_b [4];
    int idx_b = 0;
    always @(posedge latch_b or posedge clk_o_b) begin
        if (latch_b) idx_b = 0;
        else         idx_b = idx_b + 1;
    end
    always_comb begin
        serial_b = '1;
        for (int p = 0; p < 4; p++)
            if (idx_b < 16) serial_b[p] = ~pad_b[p][15 - idx_b];
    end

    // ---------------- scoreboards ----------------
    typedef struct packed {
        logic [63:0] d;
        logic [63:0] p;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [63:0] prev_a = '0;
    logic [63:0] prev_b = '0;
    logic [63:0] hold_a = '0;
    logic [63:0] hold_b = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_a = '0;
        end else if (done_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_a_unexpected: got done_o=1 expected no pulse at %0t", $time);
            end else begin
                e = q_a.pop_front();
                chk("data_a", {48'h0, data_a}, e.d);
                chk("pressed_a", {48'h0, pressed_a}, e.p);
                hold_a = e.d;
            end
        end else begin
            chk("data_a_hold", {48'h0, data_a}, hold_a);
            chk("pressed_a_idle", {48'h0, pressed_a}, 64'h0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_b = '0;
        end else if (done_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_b_unexpected: got done_o=1 expected no pulse at %0t", $time);
            end else begin
                e = q_b.pop_front();
                chk("data_b", data_b, e.d);
                chk("pressed_b", pressed_b, e.p);
                hold_b = e.d;
            end
        end else begin
            chk("data_b_hold", data_b, hold_b);
            chk("pressed_b_idle", pressed_b, 64'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic poll_a(input logic [7:0] p0, input logic [7:0] p1, input bit extra);
        exp_t e;
        int   done_at, dones, latch_cnt, rises;
        bit   busy_ok, clk_low_ok, clk_prev;
        pad_a[0] = p0;
        pad_a[1] = p1;
        e.d = {48'h0, p1, p0};
`ifdef CONTROLLER_PRESS_DETECT_EN
        e.p = e.d & ~prev_a;
`else
        e.p = '0;
`endif
        prev_a = e.d;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        done_at = -1; dones = 0; latch_cnt = 0; rises = 0;
        busy_ok = 1'b1; clk_low_ok = 1'b1; clk_prev = 1'b0;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            start_a = extra && (c == 10 || c == 40);
            if (c <= 81 && !busy_a) busy_ok = 1'b0;
            if (latch_a) begin
                latch_cnt++;
                if (clk_o_a) clk_low_ok = 1'b0;
            end
            if (clk_o_a && !clk_prev) rises++;
            clk_prev = clk_o_a;
            if (done_a) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (done_at > 0 && c >= done_at + 3) break;
        end
        start_a = 1'b0;
        chk("a_done_latency", done_at, 81);
        chk("a_done_count", dones, 1);
        chk("a_busy_continuous", {63'h0, busy_ok}, 64'h1);
        chk("a_latch_cycles", latch_cnt, 16);
        chk("a_clk_low_in_latch", {63'h0, clk_low_ok}, 64'h1);
        chk("a_clk_rises", rises, 8);
        chk("a_busy_after", {63'h0, busy_a}, 64'h0);
    endtask

    task automatic poll_b(input logic [63:0] pads);
        exp_t e;
        int   done_at, rises;
        bit   clk_prev;
        for (int p = 0; p < 4; p++) pad_b[p] = pads[p*16 +: 16];
        e.d = pads;
`ifdef CONTROLLER_PRESS_DETECT_EN
        e.p = e.d & ~prev_b;
`else
        e.p = '0;
`endif
        prev_b = e.d;
        q_b.push_back(e);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        done_at = -1; rises = 0; clk_prev = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (clk_o_b && !clk_prev) rises++;
            clk_prev = clk_o_b;
            if (done_b && done_at < 0) done_at = c;
            if (done_at > 0 && c >= done_at + 3) break;
        end
        chk("b_done_latency", done_at, 35);
        chk("b_clk_rises", rises, 16);
    endtask

    initial begin
        pad_a[0] = '0; pad_a[1] = '0;
        for (int p = 0; p < 4; p++) pad_b[p] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'h0, busy_a}, 64'h0);
        chk("rst_done", {63'h0, done_a}, 64'h0);
        chk("rst_clk_o", {63'h0, clk_o_a}, 64'h0);
        chk("rst_latch", {63'h0, latch_a}, 64'h0);
        chk("rst_data", {48'h0, data_a}, 64'h0);
        chk("rst_pressed", {48'h0, pressed_a}, 64'h0);

        // Buttons 1 and 3 on pad0 -> 16'h00A0, with ignored mid-poll requests.
        poll_a(8'hA0, 8'h00, 1'b1);
        poll_a(8'h01, 8'h5A, 1'b0);
        poll_a(8'h03, 8'hFF, 1'b0);
        poll_a(8'h03, 8'hFF, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        pad_a[0] = 8'h77; pad_a[1] = 8'h11;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_clk_o", {63'h0, clk_o_a}, 64'h0);
        chk("arst_latch", {63'h0, latch_a}, 64'h0);
        chk("arst_data", {48'h0, data_a}, 64'h0);
        chk("arst_busy", {63'h0, busy_a}, 64'h0);
        chk("arst_done", {63'h0, done_a}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_a = '0;
        prev_b = '0;
        repeat (100) @(negedge clk);
        chk("arst_idle_busy", {63'h0, busy_a}, 64'h0);
        poll_a(8'h81, 8'h3C, 1'b0);

        poll_b(64'h1234_ABCD_8001_FFFE);
        poll_b(64'h0000_FFFF_5555_0F0F);

        repeat (5) @(negedge clk);
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
